ones_count_accumulator: RTL

//   Downstream consumer of the 7-bit ones-counter stage: takes its 3-bit count (0..7) per word
//   and accumulates FRAME_LEN accepted counts into one frame total. Valid/ready on both sides;

---
 rtl/ones_count_accumulator_if.sv | 24 ++
 rtl/ones_count_accumulator.sv | 125 ++++++++++++
 2 files changed

// File: rtl/ones_count_accumulator_if.sv
// Valid/ready bus between the ones-counter stage, the frame accumulator and its consumer.
// The slave modport is the accumulator's view of the bus.
interface ones_count_accumulator_if #(
  parameter int unsigned SUM_W = 6
);
  logic             in_valid;
  logic [2:0]       cnt_in;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [SUM_W-1:0] sum_out;
  logic             over_thresh;
  logic             sat;

  modport master (
    output in_valid, cnt_in, out_ready,
    input  in_ready, out_valid, sum_out, over_thresh, sat
  );

  modport slave (
    input  in_valid, cnt_in, out_ready,
    output in_ready, out_valid, sum_out, over_thresh, sat
  );
endinterface

// File: rtl/ones_count_accumulator.sv
// Accumulates FRAME_LEN 3-bit ones counts into a saturating frame total.
// The total is held under valid/ready until taken, with threshold and saturation flags.
module ones_count_accumulator #(
  parameter int unsigned FRAME_LEN = 8,
  parameter int unsigned SUM_W     = 6,
  parameter int unsigned THRESH    = 28
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  output logic                       busy_o,
  ones_count_accumulator_if.slave    bus
);

  localparam int unsigned CNT_W  = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int unsigned EXT_W  = SUM_W + 1;
  localparam logic [CNT_W-1:0] LAST_WORD  = CNT_W'(FRAME_LEN - 1);
  localparam logic [EXT_W-1:0] THRESH_EXT = EXT_W'(THRESH);
  localparam logic [SUM_W-1:0] SUM_MAX    = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e           state_q;
  logic [SUM_W-1:0] acc_q;
  logic [CNT_W-1:0] word_cnt_q;
  logic [SUM_W-1:0] sum_q;
  logic             over_q;
  logic             sat_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             busy_q;

  logic [EXT_W-1:0] sum_ext_c;
  logic             clip_c;
  logic [SUM_W-1:0] acc_d;

  // Add one bit wider than the accumulator, then clip to all-ones instead of wrapping.
  always_comb begin
    sum_ext_c = {1'b0, acc_q} + EXT_W'(bus.cnt_in);
    clip_c    = sum_ext_c[SUM_W];
    acc_d     = clip_c ? SUM_MAX : sum_ext_c[SUM_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      word_cnt_q  <= '0;
      sum_q       <= '0;
      over_q      <= 1'b0;
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            word_cnt_q <= '0;
            sat_q      <= 1'b0;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
          end
        end

        ACCUM: begin
          if (bus.in_valid && in_ready_q) begin
            acc_q <= acc_d;
            if (clip_c) begin
              sat_q <= 1'b1;
            end
            if (word_cnt_q == LAST_WORD) begin
              state_q     <= HOLD;
              word_cnt_q  <= '0;
              sum_q       <= acc_d;
              over_q      <= ({1'b0, acc_d} >= THRESH_EXT);
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              word_cnt_q <= word_cnt_q + CNT_W'(1);
            end
          end
        end

        HOLD: begin
          // A start coincident with the handshake skips IDLE and opens the next frame.
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            if (start_i) begin
              state_q    <= ACCUM;
              acc_q      <= '0;
              word_cnt_q <= '0;
              sat_q      <= 1'b0;
              in_ready_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end

        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.sum_out     = sum_q;
  assign bus.over_thresh = over_q;
  assign bus.sat         = sat_q;
  assign busy_o          = busy_q;

endmodule
